// File: rtl/button_hold_detect.sv
`default_nettype none
// ============================================================================
//  Module   : button_hold_detect
//  Purpose  : Multi-channel active-low push-button front end. Each channel
//             synchronises its button, debounces press and release, reports
//             short/long presses and optional auto-repeat while held.
//  Revision : 1.0  initial release
// ============================================================================
module button_hold_detect #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 0,
    parameter int CNT_W           = $clog2(
        ((DEBOUNCE_CYCLES > HOLD_CYCLES)
            ? ((DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES)
            : ((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES)) + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] btn_n,
    output logic [NUM_CH-1:0] pressed,
    output logic [NUM_CH-1:0] held,
    output logic [NUM_CH-1:0] short_pulse,
    output logic [NUM_CH-1:0] long_pulse,
    output logic [NUM_CH-1:0] repeat_pulse
);

    // Compare values, pre-sized to the counter width. The repeat compare is
    // forced to zero when repeat is disabled so it never goes negative.
    localparam logic [CNT_W-1:0] c_DEB_CMP   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_REP_LAST  = CNT_W'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEB_PRESS = 3'd1,
        ST_PRESSED   = 3'd2,
        ST_HELD      = 3'd3,
        ST_DEB_REL_P = 3'd4,
        ST_DEB_REL_H = 3'd5
    } state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             sync1_q;
        logic             sync2_q;
        state_t           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] rel_cnt_q;
        logic             pressed_q;
        logic             held_q;
        logic             short_q;
        logic             long_q;
        logic             repeat_q;
        logic             w_s;
        logic [CNT_W-1:0] w_cnt_inc;
        logic [CNT_W-1:0] w_rel_inc;

        assign w_s = sync2_q;

        // Saturating increments: the compares bound the counts, but a counter
        // must never wrap even if a compare value is unreachable.
        assign w_cnt_inc = (cnt_q == c_CNT_MAX) ? cnt_q : (cnt_q + c_CNT_ONE);
        assign w_rel_inc = (rel_cnt_q == c_CNT_MAX) ? rel_cnt_q : (rel_cnt_q + c_CNT_ONE);

        // Synchroniser plus per-channel press/hold/release state machine.
        // A glitch that returns to PRESSED/HELD takes a normal counting step
        // on the return edge, so only the cycles actually spent high are lost.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q   <= 1'b1;
                sync2_q   <= 1'b1;
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                rel_cnt_q <= '0;
                pressed_q <= 1'b0;
                held_q    <= 1'b0;
                short_q   <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                sync1_q  <= btn_n[i];
                sync2_q  <= sync1_q;
                short_q  <= 1'b0;
                long_q   <= 1'b0;
                repeat_q <= 1'b0;

                case (state_q)
                    ST_IDLE: begin
                        if (!w_s) begin
                            state_q <= ST_DEB_PRESS;
                            cnt_q   <= c_CNT_ONE;
                        end
                    end

                    ST_DEB_PRESS: begin
                        if (w_s) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == c_DEB_CMP) begin
                            state_q   <= ST_PRESSED;
                            cnt_q     <= '0;
                            pressed_q <= 1'b1;
                        end else begin
                            cnt_q <= w_cnt_inc;
                        end
                    end

                    ST_PRESSED, ST_DEB_REL_P: begin
                        if (!w_s) begin
                            if (cnt_q == c_HOLD_LAST) begin
                                state_q <= ST_HELD;
                                cnt_q   <= '0;
                                long_q  <= 1'b1;
                                held_q  <= 1'b1;
                            end else begin
                                state_q <= ST_PRESSED;
                                cnt_q   <= w_cnt_inc;
                            end
                        end else if (state_q == ST_PRESSED) begin
                            state_q   <= ST_DEB_REL_P;
                            rel_cnt_q <= c_CNT_ONE;
                        end else if (rel_cnt_q == c_DEB_CMP) begin
                            state_q   <= ST_IDLE;
                            cnt_q     <= '0;
                            rel_cnt_q <= '0;
                            pressed_q <= 1'b0;
                            short_q   <= 1'b1;
                        end else begin
                            rel_cnt_q <= w_rel_inc;
                        end
                    end

                    ST_HELD, ST_DEB_REL_H: begin
                        if (!w_s) begin
                            state_q <= ST_HELD;
                            if (REPEAT_CYCLES > 0) begin
                                if (cnt_q == c_REP_LAST) begin
                                    cnt_q    <= '0;
                                    repeat_q <= 1'b1;
                                end else begin
                                    cnt_q <= w_cnt_inc;
                                end
                            end
                        end else if (state_q == ST_HELD) begin
                            state_q   <= ST_DEB_REL_H;
                            rel_cnt_q <= c_CNT_ONE;
                        end else if (rel_cnt_q == c_DEB_CMP) begin
                            state_q   <= ST_IDLE;
                            cnt_q     <= '0;
                            rel_cnt_q <= '0;
                            pressed_q <= 1'b0;
                            held_q    <= 1'b0;
                        end else begin
                            rel_cnt_q <= w_rel_inc;
                        end
                    end

                    default: begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        rel_cnt_q <= '0;
                        pressed_q <= 1'b0;
                        held_q    <= 1'b0;
                    end
                endcase
            end
        end

        assign pressed[i]      = pressed_q;
        assign held[i]         = held_q;
        assign short_pulse[i]  = short_q;
        assign long_pulse[i]   = long_q;
        assign repeat_pulse[i] = repeat_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_button_hold_detect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_hold_detect
//  Purpose  : Directed bench. Stimulus pushes expected output events into a
//             queue; a negedge monitor pops and compares every output event.
//  Revision : 1.0  initial release
// ============================================================================
module tb_button_hold_detect;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] btn_m;
    logic [1:0] btn_nr;
    logic [1:0] p_m, h_m, s_m, l_m, r_m;
    logic [1:0] p_nr, h_nr, s_nr, l_nr, r_nr;

    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_mis = 0;

    // Main instance with repeat enabled.
    button_hold_detect #(
        .NUM_CH(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_m),
        .pressed(p_m), .held(h_m), .short_pulse(s_m),
        .long_pulse(l_m), .repeat_pulse(r_m)
    );

    // Second instance with repeat disabled.
    button_hold_detect #(
        .NUM_CH(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(0)
    ) dut_nr (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_nr),
        .pressed(p_nr), .held(h_nr), .short_pulse(s_nr),
        .long_pulse(l_nr), .repeat_pulse(r_nr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combined 4-channel view: {dut_nr ch1, dut_nr ch0, dut ch1, dut ch0}.
    typedef struct packed {
        int unsigned c;
        logic [3:0]  p;
        logic [3:0]  h;
        logic [3:0]  s;
        logic [3:0]  l;
        logic [3:0]  r;
    } ev_t;

    ev_t exp_q[$];

    task automatic expect_ev(input int unsigned c, input logic [3:0] p, input logic [3:0] h,
                             input logic [3:0] s, input logic [3:0] l, input logic [3:0] r);
        ev_t e;
        e.c = c; e.p = p; e.h = h; e.s = s; e.l = l; e.r = r;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: an event is any level change on pressed/held or any pulse.
    logic [3:0] prev_p = 4'hF;
    logic [3:0] prev_h = 4'hF;
    ev_t        act;
    ev_t        want;

    always @(negedge clk) begin
        act.c = cyc;
        act.p = {p_nr, p_m};
        act.h = {h_nr, h_m};
        act.s = {s_nr, s_m};
        act.l = {l_nr, l_m};
        act.r = {r_nr, r_m};
        if (act.p !== prev_p || act.h !== prev_h || (act.s | act.l | act.r) !== 4'h0) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $display("FAIL unexpected_event cyc=%0d got p=%b h=%b s=%b l=%b r=%b, required no event",
                         act.c, act.p, act.h, act.s, act.l, act.r);
            end else begin
                want = exp_q.pop_front();
                if (act !== want) begin
                    n_mis++;
                    $display("FAIL event got cyc=%0d p=%b h=%b s=%b l=%b r=%b, required cyc=%0d p=%b h=%b s=%b l=%b r=%b",
                             act.c, act.p, act.h, act.s, act.l, act.r,
                             want.c, want.p, want.h, want.s, want.l, want.r);
                end
            end
        end
        prev_p = act.p;
        prev_h = act.h;
    end

    int unsigned t0;

    initial begin
        rst_n  = 1'b0;
        btn_m  = 2'b11;
        btn_nr = 2'b11;
        // Reset state: all outputs zero at the first sample.
        expect_ev(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        tick(3);
        rst_n = 1'b1;
        tick(5);

        // 1: clean short press on ch0.
        t0 = cyc;
        btn_m[0] = 1'b0;
        expect_ev(t0 + 7,  4'b0001, 4'h0, 4'h0, 4'h0, 4'h0);
        expect_ev(t0 + 17, 4'b0000, 4'h0, 4'b0001, 4'h0, 4'h0);
        tick(10);
        btn_m[0] = 1'b1;
        tick(30);

        // 2: bounce with low runs of 3 cycles, never accepted.
        for (int k = 0; k < 6; k++) begin
            btn_m[0] = 1'b0;
            tick(3);
            btn_m[0] = 1'b1;
            tick(2);
        end
        tick(20);

        // 3: long hold on ch1 with auto-repeat.
        t0 = cyc;
        btn_m[1] = 1'b0;
        expect_ev(t0 + 7,  4'b0010, 4'h0,    4'h0, 4'h0,    4'h0);
        expect_ev(t0 + 27, 4'b0010, 4'b0010, 4'h0, 4'b0010, 4'h0);
        expect_ev(t0 + 32, 4'b0010, 4'b0010, 4'h0, 4'h0,    4'b0010);
        expect_ev(t0 + 37, 4'b0010, 4'b0010, 4'h0, 4'h0,    4'b0010);
        expect_ev(t0 + 42, 4'b0010, 4'b0010, 4'h0, 4'h0,    4'b0010);
        expect_ev(t0 + 47, 4'h0,    4'h0,    4'h0, 4'h0,    4'h0);
        tick(40);
        btn_m[1] = 1'b1;
        tick(20);

        // 4: 2-cycle release glitch at hold count 10 on ch0.
        t0 = cyc;
        btn_m[0] = 1'b0;
        expect_ev(t0 + 7,  4'b0001, 4'h0,    4'h0, 4'h0,    4'h0);
        expect_ev(t0 + 29, 4'b0001, 4'b0001, 4'h0, 4'b0001, 4'h0);
        expect_ev(t0 + 34, 4'b0001, 4'b0001, 4'h0, 4'h0,    4'b0001);
        expect_ev(t0 + 39, 4'b0001, 4'b0001, 4'h0, 4'h0,    4'b0001);
        expect_ev(t0 + 47, 4'h0,    4'h0,    4'h0, 4'h0,    4'h0);
        tick(15);
        btn_m[0] = 1'b1;
        tick(2);
        btn_m[0] = 1'b0;
        tick(23);
        btn_m[0] = 1'b1;
        tick(20);

        // 5: asynchronous reset mid-HELD on ch1, button kept low.
        t0 = cyc;
        btn_m[1] = 1'b0;
        expect_ev(t0 + 7,  4'b0010, 4'h0,    4'h0, 4'h0,    4'h0);
        expect_ev(t0 + 27, 4'b0010, 4'b0010, 4'h0, 4'b0010, 4'h0);
        expect_ev(t0 + 30, 4'h0,    4'h0,    4'h0, 4'h0,    4'h0);
        expect_ev(t0 + 39, 4'b0010, 4'h0,    4'h0, 4'h0,    4'h0);
        expect_ev(t0 + 59, 4'b0010, 4'b0010, 4'h0, 4'b0010, 4'h0);
        expect_ev(t0 + 67, 4'h0,    4'h0,    4'h0, 4'h0,    4'h0);
        tick(30);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(28);
        btn_m[1] = 1'b1;
        tick(20);

        // 6: repeat-disabled instance, hold ch0 for 60 cycles.
        t0 = cyc;
        btn_nr[0] = 1'b0;
        expect_ev(t0 + 7,  4'b0100, 4'h0,    4'h0, 4'h0,    4'h0);
        expect_ev(t0 + 27, 4'b0100, 4'b0100, 4'h0, 4'b0100, 4'h0);
        expect_ev(t0 + 67, 4'h0,    4'h0,    4'h0, 4'h0,    4'h0);
        tick(60);
        btn_nr[0] = 1'b1;
        tick(20);

        // Any expected event never observed is a miscompare.
        while (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            n_vec++;
            n_mis++;
            $display("FAIL missing_event got none, required cyc=%0d p=%b h=%b s=%b l=%b r=%b",
                     want.c, want.p, want.h, want.s, want.l, want.r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
